// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the FFT output-side blocks.
// The sample serializer and its index counter both import this package.
package fft_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fft_ser_state_t;

  localparam int FFT_DEFAULT_N_SAMPLES = 8;
  localparam int FFT_DEFAULT_IDX_W     = $clog2(FFT_DEFAULT_N_SAMPLES);

  // Index width for a frame of n_samples; never narrower than one bit.
  function automatic int fft_idx_width(input int n_samples);
    return (n_samples < 2) ? 1 : $clog2(n_samples);
  endfunction

endpackage

// File: rtl/fft_index_counter.sv
// Saturating up-counter used to walk a frame's sample index.
// It stops at MAX_VALUE and flags that value on at_max.
module fft_index_counter
  import fft_pkg::*;
#(
  parameter int WIDTH     = FFT_DEFAULT_IDX_W,
  parameter int MAX_VALUE = FFT_DEFAULT_N_SAMPLES - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr && !at_max) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == WIDTH'(MAX_VALUE));

endmodule

// File: rtl/fft_sample_serializer.sv
// Buffers one packed frame of fixed-point samples and streams it out
// sample 0 first, one sample per val/rdy handshake.
module fft_sample_serializer
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = FFT_DEFAULT_N_SAMPLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg,
  input  logic                          recv_val,
  output logic                          recv_rdy,
  output logic [BIT_WIDTH-1:0]          send_msg,
  output logic                          send_val,
  input  logic                          send_rdy,
  output logic                          send_last
);

  localparam int IDX_W = fft_idx_width(N_SAMPLES);

  if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0 || DECIMAL_PT > BIT_WIDTH) begin : g_bad_params
    $error("fft_sample_serializer: N_SAMPLES must be a power of two >= 2 and DECIMAL_PT <= BIT_WIDTH");
  end

  fft_ser_state_t state_q;
  fft_ser_state_t state_d;

  logic [BIT_WIDTH-1:0] buffer_q [N_SAMPLES-1:0];
  logic [BIT_WIDTH-1:0] buffer_d [N_SAMPLES-1:0];

  logic [IDX_W-1:0] index;
  logic             index_at_max;
  logic             capture;
  logic             send_fire;

  assign capture   = recv_val && recv_rdy;
  assign send_fire = send_val && send_rdy;

  fft_index_counter #(
    .WIDTH     (IDX_W),
    .MAX_VALUE (N_SAMPLES - 1)
  ) u_index (
    .clk    (clk),
    .reset  (reset),
    .clear  (capture || (send_fire && index_at_max)),
    .incr   (send_fire && !index_at_max),
    .count  (index),
    .at_max (index_at_max)
  );

  // Outputs depend only on registered state; reset forces them idle.
  always_comb begin
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    send_last = 1'b0;
    send_msg  = '0;
    if (!reset) begin
      if (state_q == IDLE) begin
        recv_rdy = 1'b1;
      end else begin
        send_val  = 1'b1;
        send_last = index_at_max;
        send_msg  = buffer_q[index];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SEND;
      SEND:    if (send_fire && index_at_max) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buffer_d = buffer_q;
    if (capture) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        buffer_d[i] = recv_msg[BIT_WIDTH*i +: BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < N_SAMPLES; i++) begin
        buffer_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
    end
  end

endmodule

// File: tb/tb_fft_sample_serializer.sv
// Directed bench for fft_sample_serializer (N=8, 32-bit samples): a vector
// table for reset and one free-running frame, then hand-written corner cases.
module tb_fft_sample_serializer;

  localparam int BW = 32;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [BW*N-1:0] recv_msg;
  logic            recv_val;
  logic            recv_rdy;
  logic [BW-1:0]   send_msg;
  logic            send_val;
  logic            send_rdy;
  logic            send_last;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic            rst;
    logic            rv;
    logic [BW*N-1:0] msg;
    logic            sr;
    logic            exp_recv_rdy;
    logic            exp_send_val;
    logic [BW-1:0]   exp_send_msg;
    logic            exp_send_last;
  } vec_t;

  vec_t vecs[13];

  fft_sample_serializer #(
    .BIT_WIDTH  (BW),
    .DECIMAL_PT (16),
    .N_SAMPLES  (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .recv_msg  (recv_msg),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .send_msg  (send_msg),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_last (send_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Distinct, recognisable sample values for the hand-written sequences.
  function automatic logic [BW-1:0] sample_word(input int kind, input int idx);
    return {8'(kind), 8'h5A, 16'(idx * 17 + kind)};
  endfunction

  function automatic logic [BW*N-1:0] pack_frame(input int kind);
    logic [BW*N-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[BW*i +: BW] = sample_word(kind, i);
    return f;
  endfunction

  task automatic applyStimulus(input logic rst, input logic rv,
                               input logic [BW*N-1:0] msg, input logic sr);
    @(negedge clk);
    reset    = rst;
    recv_val = rv;
    recv_msg = msg;
    send_rdy = sr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [BW-1:0] actual,
                             input logic [BW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input logic rr, input logic sv,
                            input logic [BW-1:0] msg, input logic last);
    checkOutput({tag, ".recv_rdy"},  BW'(recv_rdy),  BW'(rr));
    checkOutput({tag, ".send_val"},  BW'(send_val),  BW'(sv));
    checkOutput({tag, ".send_msg"},  send_msg,       msg);
    checkOutput({tag, ".send_last"}, BW'(send_last), BW'(last));
  endtask

  initial begin
    logic [BW*N-1:0] frame_a;
    int exp_idx;
    int handshakes;
    int cyc;
    logic sr;

    reset    = 1'b1;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b0;

    frame_a = '0;
    for (int i = 0; i < N; i++) frame_a[BW*i +: BW] = 32'h0001_0000 * (i + 1);

    vecs[0]  = '{1'b1, 1'b1, frame_a, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, frame_a, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, frame_a, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, frame_a, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0001_0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0002_0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0003_0000, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0004_0000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0005_0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0006_0000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0007_0000, 1'b0};
    vecs[11] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0008_0000, 1'b1};
    vecs[12] = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};

    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].rv, vecs[v].msg, vecs[v].sr);
      checkCycle($sformatf("vec%0d", v), vecs[v].exp_recv_rdy, vecs[v].exp_send_val,
                 vecs[v].exp_send_msg, vecs[v].exp_send_last);
    end

    // Backpressure: send_rdy pattern 1,0,0,1 repeating.
    applyStimulus(1'b0, 1'b1, pack_frame(1), 1'b0);
    checkCycle("bp_capture", 1'b1, 1'b0, 32'h0, 1'b0);
    exp_idx    = 0;
    handshakes = 0;
    cyc        = 0;
    while (handshakes < N && cyc < 64) begin
      sr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      applyStimulus(1'b0, 1'b1, pack_frame(9), sr);
      checkCycle($sformatf("bp_cyc%0d", cyc), 1'b0, 1'b1, sample_word(1, exp_idx),
                 exp_idx == N - 1);
      if (sr) begin
        handshakes++;
        exp_idx++;
      end
      cyc++;
    end
    checkOutput("bp_handshakes", BW'(handshakes), BW'(N));
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkCycle("bp_idle", 1'b1, 1'b0, 32'h0, 1'b0);

    // Input change after capture: new recv_msg with recv_val=1 during SEND.
    applyStimulus(1'b0, 1'b1, pack_frame(2), 1'b1);
    checkCycle("chg_capture", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, pack_frame(3), 1'b1);
      checkCycle($sformatf("chg_s%0d", i), 1'b0, 1'b1, sample_word(2, i), i == N - 1);
    end
    applyStimulus(1'b0, 1'b0, pack_frame(3), 1'b1);
    checkCycle("chg_idle", 1'b1, 1'b0, 32'h0, 1'b0);

    // Back-to-back: recv_val held high, one IDLE cycle between frames.
    applyStimulus(1'b0, 1'b1, pack_frame(4), 1'b1);
    checkCycle("b2b_capA", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, pack_frame(5), 1'b1);
      checkCycle($sformatf("b2b_A%0d", i), 1'b0, 1'b1, sample_word(4, i), i == N - 1);
    end
    applyStimulus(1'b0, 1'b1, pack_frame(5), 1'b1);
    checkCycle("b2b_gap", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, pack_frame(5), 1'b1);
      checkCycle($sformatf("b2b_B%0d", i), 1'b0, 1'b1, sample_word(5, i), i == N - 1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkCycle("b2b_idle", 1'b1, 1'b0, 32'h0, 1'b0);

    // Reset mid-frame after sample 3, then a fresh frame starts at sample 0.
    applyStimulus(1'b0, 1'b1, pack_frame(6), 1'b1);
    checkCycle("rst_capture", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkCycle($sformatf("rst_s%0d", i), 1'b0, 1'b1, sample_word(6, i), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, pack_frame(8), 1'b1);
      checkCycle($sformatf("rst_hold%0d", i), 1'b0, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, pack_frame(7), 1'b1);
    checkCycle("rst_release", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkCycle($sformatf("rst_new%0d", i), 1'b0, 1'b1, sample_word(7, i), i == N - 1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkCycle("rst_final_idle", 1'b1, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fft_sample_serializer.md
# fft_sample_serializer

Output-side adapter for the FFT datapath: accepts one packed frame of `N_SAMPLES` fixed-point samples on a val/rdy port and streams the samples out one per handshake on a narrow val/rdy port. It sits downstream of the FFT (or its test harness) wherever a flat `BIT_WIDTH*N_SAMPLES` bus must feed a sample-serial consumer such as a sink FIFO, a magnitude block or a host link. The frame is buffered internally, so the upstream FFT is released as soon as the frame is captured.

## Interface
- `BIT_WIDTH`, 32, width of one sample (fixed-point, passed through untouched)
- `DECIMAL_PT`, 16, fractional bits; informational only, no arithmetic is performed
- `N_SAMPLES`, 8, samples per frame; legal values are ≥2 and a power of two
- `clk` input 1: sole clock; all state updates on its rising edge
- `reset` input 1: synchronous, active-high
- `recv_msg` input `BIT_WIDTH*N_SAMPLES`: packed frame; sample i occupies `[BIT_WIDTH*i +: BIT_WIDTH]`
- `recv_val` input 1: frame valid
- `recv_rdy` output 1: block can capture a frame
- `send_msg` output `BIT_WIDTH`: current sample
- `send_val` output 1: sample valid
- `send_rdy` input 1: consumer accepts sample
- `send_last` output 1: current sample is index `N_SAMPLES-1`

## Operation
- Two states: IDLE and SEND. Reset forces IDLE, index counter to 0 and the frame buffer to 0.
- IDLE:
  - `recv_rdy=1`, `send_val=0`, `send_last=0`, `send_msg=0`.
  - On `recv_val && recv_rdy`: capture `recv_msg` into the frame buffer, set index to 0, go to SEND.
- SEND:
  - `recv_rdy=0`, `send_val=1`.
  - `send_msg = buffer[index]`.
  - `send_last = (index == N_SAMPLES-1)`.
- On `send_val && send_rdy`:
  - If `index == N_SAMPLES-1`: go to IDLE and clear index to 0.
  - Otherwise increment index.
- Index counter width is `$clog2(N_SAMPLES)`. The index never wraps past `N_SAMPLES-1`.
- Samples are emitted in ascending index order, sample 0 first.
- Samples are bit-exact copies of the input. `DECIMAL_PT` does not affect the datapath.
- A new frame is never accepted while SEND is active. `recv_val` is ignored outside IDLE.
- While `send_rdy=0`:
  - `send_msg`, `send_last` and `send_val` hold stable.
  - Index, state and buffer do not change.
- `recv_msg` may change freely after capture. The buffer is the only source for `send_msg`.

## Timing
- All outputs are combinational functions of the registered state, index and buffer only. There is no input→output combinational path.
- While `reset=1`: `recv_rdy=0`, `send_val=0`, `send_last=0`, `send_msg=0`. These values are forced regardless of state.
- First cycle after reset deasserts: state is IDLE and `recv_rdy=1`.
- Latency: a frame captured at edge k presents sample 0 in the cycle after edge k.
- Throughput: with `send_rdy` held high, a frame takes N_SAMPLES SEND cycles plus one IDLE cycle. That is 9 cycles for N=8.
- The last sample handshake returns the block to IDLE. `recv_rdy` rises in the following cycle; there is no same-cycle reload.
- Reset mid-frame aborts immediately:
  - Partial output is discarded.
  - The next frame starts cleanly at sample 0.
- Reset has priority over any simultaneous handshake on either port.

## Structure
- Shared package `fft_pkg`:
  - State enum `fft_ser_state_t` {IDLE, SEND}.
  - A helper localparam for index width.
- Frame buffer is an unpacked array `[N_SAMPLES-1:0]` of `BIT_WIDTH` words, loaded from the packed bus with the same slicing rule as the interface.
- One natural sub-module: `fft_index_counter`, a parameterized up-counter with:
  - synchronous `reset`, `clear` and `incr` inputs;
  - an `at_max` flag.
- The FSM and output mux stay in the top module.

## Test plan
- **Reset.** Hold `reset` 3 cycles with `recv_val=1` → `recv_rdy=0`, `send_val=0`, `send_msg=0` throughout. `recv_rdy=1` in the first cycle after release.
- **Single frame, free sink.**
  - Stimulus: N=8, BIT_WIDTH=32, frame samples 0x00010000·(i+1) with `send_rdy=1`.
  - Output: 0x00010000, 0x00020000, … 0x00080000 on 8 consecutive cycles.
  - `send_last` is asserted only on 0x00080000. `recv_rdy=1` again on cycle 9.
- **Backpressure.**
  - Stimulus: toggle `send_rdy` 1,0,0,1,… during a frame.
  - `send_msg` and `send_last` hold while `send_rdy=0`.
  - Exactly 8 handshakes occur, with no duplicates or drops.
- **Input change after capture.**
  - Stimulus: capture a frame, then drive a different `recv_msg` with `recv_val=1` during SEND.
  - Output: the original samples are streamed and `recv_rdy` stays 0.
- **Back-to-back frames.**
  - Stimulus: `recv_val` held high with two distinct frames.
  - Output: 16 samples in order, with exactly one IDLE cycle between sample 7 of frame A and sample 0 of frame B.
- **Reset mid-frame.** Assert `reset` after sample 3 → outputs forced idle. A new frame then emits its own sample 0 first.
